// File: rtl/mb_sessao_seq_pkg.sv
// Shared definitions for the multibanco session sequencer: FSM states,
// display status codes and operation codes.
package mb_sessao_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PIN  = 3'd1,
    S_MENU = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4,
    S_LOCK = 3'd5
  } state_t;

  localparam logic [6:0] ST_IDLE   = 7'd0;
  localparam logic [6:0] ST_PIN    = 7'd1;
  localparam logic [6:0] ST_WRONG  = 7'd2;
  localparam logic [6:0] ST_MENU   = 7'd3;
  localparam logic [6:0] ST_OK     = 7'd4;
  localparam logic [6:0] ST_FUNDS  = 7'd5;
  localparam logic [6:0] ST_INVCOD = 7'd6;
  localparam logic [6:0] ST_OVF    = 7'd7;
  localparam logic [6:0] ST_LOCK   = 7'd9;

  localparam int OP_LEVANTAR  = 1;
  localparam int OP_DEPOSITAR = 2;
  localparam int OP_CONSULTA  = 3;

endpackage

// File: rtl/mb_bin2bcd2.sv
// Binary (0..99) to two BCD digits for the 7-segment drivers.
module mb_bin2bcd2 (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  assign tens_o  = 4'(bin_i / 7'd10);
  assign units_o = 4'(bin_i % 7'd10);

endmodule

// File: rtl/mb_sessao_seq.sv
// ATM session sequencer: PIN check with lockout, operation menu and
// withdraw/deposit/query on an internal balance, shown as registered BCD.
module mb_sessao_seq
  import mb_sessao_seq_pkg::*;
#(
  parameter int               DATA_W    = 5,
  parameter int               PIN_W     = 5,
  parameter int               COD_W     = 6,
  parameter logic [PIN_W-1:0] PIN_OK    = PIN_W'(13),
  parameter int               MAX_TRIES = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              LOAD_SALDO,
  input  logic [DATA_W-1:0] SALDO_IN,
  input  logic [PIN_W-1:0]  PIN,
  input  logic              PIN_VALID,
  input  logic [COD_W-1:0]  COD,
  input  logic [DATA_W-1:0] VAL,
  input  logic              CONFIRM,
  output logic [3:0]        ECRA_OUT1,
  output logic [3:0]        ECRA_OUT0,
  output logic [3:0]        SALDO_OUT1,
  output logic [3:0]        SALDO_OUT0,
  output logic [3:0]        VAL_OUT1,
  output logic [3:0]        VAL_OUT0,
  output logic [3:0]        COD_OUT1,
  output logic [3:0]        COD_OUT0,
  output logic              PAR_OUT,
  output logic              BLOCKED,
  output logic              BUSY
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bal_q, bal_d;
  logic [2:0]          tries_q, tries_d;
  logic [6:0]          status_q, status_d;
  logic [COD_W-1:0]    cod_q, cod_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [DATA_W:0]     sum;
  logic [2:0]          tries_inc;

  logic [3:0] ecra_t, ecra_u, saldo_t, saldo_u, val_t, val_u, cod_t, cod_u;

  // Next-state and datapath decisions; EN low aborts any live session.
  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    tries_d   = tries_q;
    status_d  = status_q;
    cod_d     = cod_q;
    val_d     = val_q;
    sum       = {1'b0, bal_q} + {1'b0, val_q};
    tries_inc = tries_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        status_d = ST_IDLE;
        if (LOAD_SALDO) bal_d = SALDO_IN;
        if (EN) begin
          state_d  = S_PIN;
          status_d = ST_PIN;
        end
      end
      S_PIN: begin
        if (!EN) begin
          state_d  = S_IDLE;
          status_d = ST_IDLE;
        end else if (PIN_VALID) begin
          if (PIN == PIN_OK) begin
            tries_d  = 3'd0;
            state_d  = S_MENU;
            status_d = ST_MENU;
          end else begin
            tries_d = tries_inc;
            if (tries_inc >= 3'(MAX_TRIES)) begin
              state_d  = S_LOCK;
              status_d = ST_LOCK;
            end else begin
              status_d = ST_WRONG;
            end
          end
        end
      end
      S_MENU: begin
        if (!EN) begin
          state_d  = S_IDLE;
          status_d = ST_IDLE;
        end else if (CONFIRM) begin
          cod_d   = COD;
          val_d   = VAL;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!EN) begin
          state_d  = S_IDLE;
          status_d = ST_IDLE;
        end else begin
          state_d = S_DONE;
          if (cod_q == COD_W'(OP_LEVANTAR)) begin
            if (val_q <= bal_q) begin
              bal_d    = bal_q - val_q;
              status_d = ST_OK;
            end else begin
              status_d = ST_FUNDS;
            end
          end else if (cod_q == COD_W'(OP_DEPOSITAR)) begin
            if (!sum[DATA_W]) begin
              bal_d    = sum[DATA_W-1:0];
              status_d = ST_OK;
            end else begin
              status_d = ST_OVF;
            end
          end else if (cod_q == COD_W'(OP_CONSULTA)) begin
            status_d = ST_OK;
          end else begin
            status_d = ST_INVCOD;
          end
        end
      end
      S_DONE: begin
        if (!EN) begin
          state_d  = S_IDLE;
          status_d = ST_IDLE;
        end else begin
          state_d  = S_MENU;
          status_d = ST_MENU;
        end
      end
      S_LOCK: begin
        status_d = ST_LOCK;
      end
      default: begin
        state_d  = S_IDLE;
        status_d = ST_IDLE;
      end
    endcase
  end

  // Session state, balance, attempt counter and sampled operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      bal_q    <= '0;
      tries_q  <= '0;
      status_q <= ST_IDLE;
      cod_q    <= '0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      bal_q    <= bal_d;
      tries_q  <= tries_d;
      status_q <= status_d;
      cod_q    <= cod_d;
      val_q    <= val_d;
    end
  end

  mb_bin2bcd2 u_bcd_ecra  (.bin_i(status_q),   .tens_o(ecra_t),  .units_o(ecra_u));
  mb_bin2bcd2 u_bcd_saldo (.bin_i(7'(bal_q)),  .tens_o(saldo_t), .units_o(saldo_u));
  mb_bin2bcd2 u_bcd_val   (.bin_i(7'(val_q)),  .tens_o(val_t),   .units_o(val_u));
  mb_bin2bcd2 u_bcd_cod   (.bin_i(7'(cod_q)),  .tens_o(cod_t),   .units_o(cod_u));

  // Display register stage: every output is a flop fed from the session state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ECRA_OUT1  <= '0;
      ECRA_OUT0  <= '0;
      SALDO_OUT1 <= '0;
      SALDO_OUT0 <= '0;
      VAL_OUT1   <= '0;
      VAL_OUT0   <= '0;
      COD_OUT1   <= '0;
      COD_OUT0   <= '0;
      PAR_OUT    <= 1'b0;
      BLOCKED    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      ECRA_OUT1  <= ecra_t;
      ECRA_OUT0  <= ecra_u;
      SALDO_OUT1 <= saldo_t;
      SALDO_OUT0 <= saldo_u;
      VAL_OUT1   <= val_t;
      VAL_OUT0   <= val_u;
      COD_OUT1   <= cod_t;
      COD_OUT0   <= cod_u;
      PAR_OUT    <= ^cod_q;
      BLOCKED    <= (state_q == S_LOCK);
      BUSY       <= (state_q != S_IDLE) && (state_q != S_LOCK);
    end
  end

endmodule
